sht40_sequencer: RTL and testbench

Measurement controller that sequences the I2C master through one complete SHT40 temperature/humidity transaction per trigger. It presents the sensor address and measurement command, and waits out the conversion time. It then collects the six returned bytes, checks both CRC-8 words, and publishes raw 16-bit results. It sits between the processor-side logic and the I2C master, driving the master's ready/address/command/read-count inputs and monitoring its byte and state outputs.

---
 rtl/sht40_sequencer_if.sv | 26 ++
 rtl/sht40_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sht40_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sht40_sequencer_if.sv
// Handshake bundle between the SHT40 sequencer and the I2C master.
// The master modport is the sequencer's view; the slave modport is the I2C master's view.
interface sht40_sequencer_if;
  logic       Frames_Read;
  logic [3:0] Bytes_Received;
  logic [7:0] Data_Received;
  logic [2:0] Master_State_Out;
  logic       Processor_Ready;
  logic [6:0] Peripheral_Address;
  logic [7:0] Command_Data_Frames;
  logic       i2c_writes;
  logic [3:0] SHT_Reads;
  logic       CRC_Error;

  modport master (
    input  Frames_Read, Bytes_Received, Data_Received, Master_State_Out,
    output Processor_Ready, Peripheral_Address, Command_Data_Frames,
           i2c_writes, SHT_Reads, CRC_Error
  );

  modport slave (
    output Frames_Read, Bytes_Received, Data_Received, Master_State_Out,
    input  Processor_Ready, Peripheral_Address, Command_Data_Frames,
           i2c_writes, SHT_Reads, CRC_Error
  );
endinterface

// File: rtl/sht40_sequencer.sv
// Runs one SHT40 measurement per trigger: command, conversion wait, six-byte read,
// CRC-8 check of both words, then publishes raw temperature and humidity.
module sht40_sequencer #(
  parameter logic [6:0] SHT_ADDR       = 7'h44,
  parameter logic [7:0] MEAS_CMD       = 8'hFD,
  parameter int         CONV_CYCLES    = 17000,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  sht40_sequencer_if.master   bus,
  input  logic                Meas_Start,
  output logic [15:0]         Temp_Raw,
  output logic [15:0]         Hum_Raw,
  output logic                Data_Valid,
  output logic                Crc_Fail,
  output logic                Timeout,
  output logic                Busy
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CONV_MAX = CW'(CONV_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_REQ, CONV_WAIT, READ_REQ, READ_BYTES, DONE
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] conv_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bytes_q;
  logic [2:0]    idx;
  logic [7:0]    slot [6];
  logic [7:0]    crc_reg;
  logic          check_pending;
  logic          ready_q, writes_q, crc_error_q;
  logic [7:0]    cmd_q;
  logic          ready_d, writes_d, busy_d;
  logic [7:0]    cmd_d;
  logic          start_ok, byte_strobe, to_running, to_reload, to_expire;
  logic          crc_bad, crc_pass_last, timeout_abort;

  // Sensirion CRC-8: poly 0x31, MSB first, one data byte folded in per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
    return c;
  endfunction

  assign start_ok      = (state == IDLE) && Meas_Start;
  assign byte_strobe   = (state == READ_BYTES) && (bus.Bytes_Received != bytes_q);
  assign to_running    = (state == CMD_REQ) || (state == READ_REQ) || (state == READ_BYTES);
  assign to_reload     = bus.Frames_Read || byte_strobe;
  assign to_expire     = to_running && (to_cnt == TO_MAX) && !to_reload;
  assign crc_bad       = check_pending && (crc_reg != ((idx == 3'd3) ? slot[2] : slot[5]));
  assign crc_pass_last = check_pending && !crc_bad && (idx == 3'd6);

  always_comb begin
    next_state    = state;
    timeout_abort = 1'b0;
    case (state)
      IDLE:      if (Meas_Start) next_state = CMD_REQ;
      CMD_REQ: begin
        if (bus.Frames_Read) next_state = CONV_WAIT;
        else if (to_expire) begin
          next_state    = IDLE;
          timeout_abort = 1'b1;
        end
      end
      CONV_WAIT: if (conv_cnt == CONV_MAX && bus.Master_State_Out == 3'b000) next_state = READ_REQ;
      READ_REQ: begin
        if (to_expire) begin
          next_state    = IDLE;
          timeout_abort = 1'b1;
        end else next_state = READ_BYTES;
      end
      READ_BYTES: begin
        if (crc_bad) next_state = IDLE;
        else if (crc_pass_last) next_state = DONE;
        else if (to_expire) begin
          next_state    = IDLE;
          timeout_abort = 1'b1;
        end
      end
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Master-facing outputs are decoded from next_state so they land registered.
  always_comb begin
    ready_d  = (next_state == CMD_REQ) || (next_state == READ_REQ);
    writes_d = (next_state == CMD_REQ);
    cmd_d    = writes_d ? MEAS_CMD : 8'h00;
    busy_d   = (next_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      writes_q <= 1'b0;
      cmd_q    <= 8'h00;
      Busy     <= 1'b0;
    end else begin
      state    <= next_state;
      ready_q  <= ready_d;
      writes_q <= writes_d;
      cmd_q    <= cmd_d;
      Busy     <= busy_d;
    end
  end

  // A byte arriving on the same cycle as timeout expiry reloads the counter instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_cnt      <= '0;
      to_cnt        <= '0;
      bytes_q       <= 4'h0;
      idx           <= 3'd0;
      crc_reg       <= 8'hFF;
      check_pending <= 1'b0;
      crc_error_q   <= 1'b0;
      Data_Valid    <= 1'b0;
      Temp_Raw      <= 16'h0000;
      Hum_Raw       <= 16'h0000;
      Crc_Fail      <= 1'b0;
      Timeout       <= 1'b0;
      for (int i = 0; i < 6; i++) slot[i] <= 8'h00;
    end else begin
      crc_error_q   <= crc_bad;
      Data_Valid    <= crc_pass_last;
      check_pending <= byte_strobe && ((idx == 3'd2) || (idx == 3'd5));

      if (crc_pass_last) begin
        Temp_Raw <= {slot[0], slot[1]};
        Hum_Raw  <= {slot[3], slot[4]};
      end

      if (start_ok) Crc_Fail <= 1'b0;
      else if (crc_bad) Crc_Fail <= 1'b1;

      if (start_ok) Timeout <= 1'b0;
      else if (timeout_abort) Timeout <= 1'b1;

      if (state == CONV_WAIT) begin
        if (conv_cnt != CONV_MAX) conv_cnt <= conv_cnt + 1'b1;
      end else conv_cnt <= '0;

      if (!to_running || to_reload) to_cnt <= '0;
      else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;

      if (state == CONV_WAIT || state == READ_BYTES) bytes_q <= bus.Bytes_Received;

      if (state == CONV_WAIT) idx <= 3'd0;
      else if (byte_strobe) idx <= idx + 1'b1;

      if (byte_strobe) begin
        if (idx < 3'd6) slot[idx] <= bus.Data_Received;
        case (idx)
          3'd0, 3'd3: crc_reg <= crc8_byte(8'hFF, bus.Data_Received);
          3'd1, 3'd4: crc_reg <= crc8_byte(crc_reg, bus.Data_Received);
          default:    ;
        endcase
      end
    end
  end

  assign bus.Processor_Ready     = ready_q;
  assign bus.i2c_writes          = writes_q;
  assign bus.Command_Data_Frames = cmd_q;
  assign bus.CRC_Error           = crc_error_q;
  assign bus.Peripheral_Address  = SHT_ADDR;
  assign bus.SHT_Reads           = 4'd5;

endmodule

// File: tb/tb_sht40_sequencer.sv
// Directed bench for sht40_sequencer; the bench plays the I2C master through the interface.
module tb_sht40_sequencer;
  localparam int CONV = 40;
  localparam int TOUT = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Meas_Start;
  logic [15:0] Temp_Raw, Hum_Raw;
  logic        Data_Valid, Crc_Fail, Timeout, Busy;
  logic [3:0]  byteCnt;
  int          testsRun = 0;
  int          failCount = 0;

  sht40_sequencer_if bus();

  sht40_sequencer #(
    .SHT_ADDR(7'h44), .MEAS_CMD(8'hFD), .CONV_CYCLES(CONV), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master), .Meas_Start(Meas_Start),
    .Temp_Raw(Temp_Raw), .Hum_Raw(Hum_Raw), .Data_Valid(Data_Valid),
    .Crc_Fail(Crc_Fail), .Timeout(Timeout), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},  32'(Busy), 0);
    checkOutput({tag, "_ready"}, 32'(bus.Processor_Ready), 0);
    checkOutput({tag, "_wr"},    32'(bus.i2c_writes), 0);
    checkOutput({tag, "_cmd"},   32'(bus.Command_Data_Frames), 0);
    checkOutput({tag, "_crcerr"},32'(bus.CRC_Error), 0);
    checkOutput({tag, "_temp"},  32'(Temp_Raw), 0);
    checkOutput({tag, "_hum"},   32'(Hum_Raw), 0);
    checkOutput({tag, "_dv"},    32'(Data_Valid), 0);
    checkOutput({tag, "_cfail"}, 32'(Crc_Fail), 0);
    checkOutput({tag, "_tout"},  32'(Timeout), 0);
  endtask

  task automatic startMeas();
    @(posedge clk); #1 Meas_Start = 1'b1;
    @(posedge clk); #1 Meas_Start = 1'b0;
    @(negedge clk);
    checkOutput("start_ready", 32'(bus.Processor_Ready), 1);
    checkOutput("start_busy",  32'(Busy), 1);
    checkOutput("start_wr",    32'(bus.i2c_writes), 1);
    checkOutput("start_cmd",   32'(bus.Command_Data_Frames), 32'h0FD);
    checkOutput("start_cfail", 32'(Crc_Fail), 0);
    checkOutput("start_tout",  32'(Timeout), 0);
  endtask

  task automatic commandPhase();
    @(posedge clk); #1 bus.Frames_Read = 1'b1;
    @(posedge clk); #1 bus.Frames_Read = 1'b0;
  endtask

  // Counts cycles with Processor_Ready low until the read request shows up.
  task automatic convPhase(input int hold, input bit extraStart);
    int n = 0;
    int expLen = (hold > CONV) ? hold : CONV;
    if (hold > 0) bus.Master_State_Out = 3'b001;
    forever begin
      @(negedge clk);
      if (bus.Processor_Ready) break;
      n++;
      if (n == hold) bus.Master_State_Out = 3'b000;
      if (extraStart && n == 5) Meas_Start = 1'b1;
      if (extraStart && n == 6) Meas_Start = 1'b0;
      if (n > 400) break;
    end
    bus.Master_State_Out = 3'b000;
    Meas_Start = 1'b0;
    checkOutput("conv_len", 32'(n), 32'(expLen));
    @(negedge clk);
    checkOutput("read_req_1cyc", 32'(bus.Processor_Ready), 0);
  endtask

  task automatic sendBytes(input logic [47:0] data, input int count);
    for (int i = 0; i < count; i++) begin
      repeat (3) @(posedge clk);
      #1;
      byteCnt = byteCnt + 4'd1;
      bus.Data_Received  = data[47 - 8*i -: 8];
      bus.Bytes_Received = byteCnt;
    end
  endtask

  task automatic applyStimulus(input logic [47:0] data, input int hold, input bit extraStart);
    int dv = 0;
    startMeas();
    commandPhase();
    convPhase(hold, extraStart);
    sendBytes(data, 6);
    repeat (12) begin
      @(negedge clk);
      if (Data_Valid) dv++;
    end
    checkOutput("dv_pulses", 32'(dv), 1);
    checkOutput("done_cfail", 32'(Crc_Fail), 0);
    checkOutput("done_busy", 32'(Busy), 0);
  endtask

  initial begin
    int n, crcErr, dv, ready;
    rst_n = 1'b0;
    Meas_Start = 1'b0;
    byteCnt = 4'h0;
    bus.Frames_Read = 1'b0;
    bus.Bytes_Received = 4'h0;
    bus.Data_Received = 8'h00;
    bus.Master_State_Out = 3'b000;

    #12;
    checkIdleOutputs("reset");
    checkOutput("reset_addr",  32'(bus.Peripheral_Address), 32'h44);
    checkOutput("reset_reads", 32'(bus.SHT_Reads), 5);
    @(negedge clk) rst_n = 1'b1;

    // Nominal measurement
    applyStimulus(48'hBEEF92666693, 0, 1'b0);
    checkOutput("nom_temp", 32'(Temp_Raw), 32'hBEEF);
    checkOutput("nom_hum",  32'(Hum_Raw),  32'h6666);

    // Bad temperature CRC
    startMeas();
    commandPhase();
    convPhase(0, 1'b0);
    sendBytes(48'hBEEF00000000, 3);
    crcErr = 0; dv = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.CRC_Error) crcErr++;
      if (Data_Valid) dv++;
    end
    checkOutput("crc_err_pulses", 32'(crcErr), 1);
    checkOutput("crc_no_dv",      32'(dv), 0);
    checkOutput("crc_fail_flag",  32'(Crc_Fail), 1);
    checkOutput("crc_temp_kept",  32'(Temp_Raw), 32'hBEEF);
    checkOutput("crc_hum_kept",   32'(Hum_Raw), 32'h6666);
    checkOutput("crc_idle",       32'(Busy), 0);

    // Master never consumes the command frame
    startMeas();
    n = 0;
    while (!Timeout && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_set",    32'(Timeout), 1);
    checkOutput("timeout_window", 32'((n >= TOUT - 2) && (n <= TOUT + 2)), 1);
    checkOutput("timeout_ready",  32'(bus.Processor_Ready), 0);
    checkOutput("timeout_busy",   32'(Busy), 0);

    // Trigger during conversion must be ignored
    applyStimulus(48'hBEEF92666693, 0, 1'b1);
    ready = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.Processor_Ready) ready++;
    end
    checkOutput("ignored_no_retx", 32'(ready), 0);
    checkOutput("ignored_temp",    32'(Temp_Raw), 32'hBEEF);

    // Reset in the middle of the read phase
    startMeas();
    commandPhase();
    convPhase(0, 1'b0);
    sendBytes(48'hBEEF92666693, 4);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checkIdleOutputs("midrst");
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(48'h666693BEEF92, 0, 1'b0);
    checkOutput("fresh_temp", 32'(Temp_Raw), 32'h6666);
    checkOutput("fresh_hum",  32'(Hum_Raw),  32'hBEEF);

    // Byte counter wraps 4'hF -> 4'h0 mid-read, master busy stretches conversion
    byteCnt = 4'hD;
    bus.Bytes_Received = byteCnt;
    applyStimulus(48'hBEEF92666693, 60, 1'b0);
    checkOutput("wrap_temp", 32'(Temp_Raw), 32'hBEEF);
    checkOutput("wrap_hum",  32'(Hum_Raw),  32'h6666);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
